hex_display_scan: RTL and testbench



---
 rtl/hex_display_pkg.sv | 19 +
 rtl/seg7_decode.sv | 15 +
 rtl/hex_display_scan.sv | 175 +++++++++++++++++
 tb/tb_hex_display_scan.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Glyphs are active-high gfedcba; bit 7 of a catode word is the decimal point.
package hex_display_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Entry 15 is listed first so that HEX_GLYPH[n] is the glyph for nibble n.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder with decimal point and dark override.
module seg7_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       dark,
    output logic [7:0] catode
);

    always_comb begin
        catode = {dp, dark ? 7'b000_0000 : HEX_GLYPH[nibble]};
    end

endmodule

// File: rtl/hex_display_scan.sv
// Multiplexed common-anode seven-segment scanner with frame-synchronous data
// latching, leading-zero suppression, per-digit dp/blank and guard interval.
module hex_display_scan
    import hex_display_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int DIV_COUNT    = 3,
    parameter int GUARD_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*N_DIGITS-1:0]   data,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic [N_DIGITS-1:0]     blank,
    input  logic                    lz_en,
    input  logic                    data_valid,
    output logic [N_DIGITS-1:0]     anode,
    output logic [7:0]              catode,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(DIV_COUNT);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV_COUNT - 1);
    localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(N_DIGITS - 1);

    scan_state_t                state;
    scan_state_t                nxt_state;
    logic [CNT_W-1:0]           cnt;
    logic [CNT_W-1:0]           nxt_cnt;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           nxt_idx;
    logic                       tick;
    logic                       wrap;

    logic [4*N_DIGITS-1:0]      shadow_data;
    logic [N_DIGITS-1:0]        shadow_dp;
    logic [N_DIGITS-1:0]        shadow_blank;
    logic [4*N_DIGITS-1:0]      pend_data;
    logic [N_DIGITS-1:0]        pend_dp;
    logic [N_DIGITS-1:0]        pend_blank;
    logic                       pend_valid;

    logic [4*N_DIGITS-1:0]      view_data;
    logic [N_DIGITS-1:0]        view_dp;
    logic [N_DIGITS-1:0]        view_blank;
    logic [N_DIGITS-1:0]        lz_mask;
    logic [N_DIGITS-1:0]        nxt_anode;
    logic [3:0]                 sel_nib;
    logic                       sel_dp;
    logic                       sel_dark;
    logic [7:0]                 seg;

    always_comb begin
        tick      = (cnt == CNT_MAX) && enable;
        wrap      = 1'b0;
        nxt_cnt   = '0;
        nxt_idx   = '0;
        nxt_state = ST_OFF;
        if (enable) begin
            if (state == ST_OFF) begin
                nxt_state = (GUARD_CYCLES > 0) ? ST_GUARD : ST_DRIVE;
            end else begin
                nxt_cnt = tick ? '0 : cnt + 1'b1;
                nxt_idx = idx;
                if (tick) begin
                    if (idx == IDX_MAX) begin
                        nxt_idx = '0;
                        wrap    = 1'b1;
                    end else begin
                        nxt_idx = idx + 1'b1;
                    end
                end
                nxt_state = (nxt_cnt < GUARD_LIM) ? ST_GUARD : ST_DRIVE;
            end
        end
    end

    // Outputs are decoded from next-cycle state, so on a wrap the first digit
    // of the new frame must already see the incoming shadow contents.
    always_comb begin
        if (wrap && pend_valid) begin
            view_data  = pend_data;
            view_dp    = pend_dp;
            view_blank = pend_blank;
        end else begin
            view_data  = shadow_data;
            view_dp    = shadow_dp;
            view_blank = shadow_blank;
        end
    end

    // Digit 0 is excluded from the scan so a zero value still shows "0".
    always_comb begin
        logic all_zero;
        int unsigned pos;
        lz_mask  = '0;
        all_zero = 1'b1;
        pos      = 0;
        for (int unsigned k = 0; k < N_DIGITS - 1; k++) begin
            pos         = N_DIGITS - 1 - k;
            all_zero    = all_zero & (view_data[4*pos +: 4] == 4'h0);
            lz_mask[pos] = lz_en & all_zero;
        end
    end

    always_comb begin
        sel_nib   = 4'h0;
        sel_dp    = 1'b0;
        sel_dark  = 1'b0;
        nxt_anode = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (nxt_idx == IDX_W'(i)) begin
                sel_nib      = view_data[4*i +: 4];
                sel_dp       = view_dp[i] & ~view_blank[i];
                sel_dark     = view_blank[i] | lz_mask[i];
                nxt_anode[i] = 1'b1;
            end
        end
    end

    seg7_decode u_decode (
        .nibble (sel_nib),
        .dp     (sel_dp),
        .dark   (sel_dark),
        .catode (seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_GUARD;
            cnt          <= '0;
            idx          <= '0;
            anode        <= '0;
            catode       <= SEG_BLANK;
            frame_done   <= 1'b0;
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
            pend_data    <= '0;
            pend_dp      <= '0;
            pend_blank   <= '0;
            pend_valid   <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            idx        <= nxt_idx;
            frame_done <= wrap;
            if (nxt_state == ST_DRIVE) begin
                anode  <= nxt_anode;
                catode <= seg;
            end else begin
                anode  <= '0;
                catode <= SEG_BLANK;
            end
            if (data_valid) begin
                pend_data  <= data;
                pend_dp    <= dp;
                pend_blank <= blank;
            end
            // A write landing on the wrap edge stays pending for the next frame.
            if (wrap && pend_valid) begin
                shadow_data  <= pend_data;
                shadow_dp    <= pend_dp;
                shadow_blank <= pend_blank;
                pend_valid   <= data_valid;
            end else if (data_valid) begin
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan (4 digits, 3-cycle slots, 1 guard cycle).
module tb_hex_display_scan;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_en;
    logic        data_valid;
    logic [3:0]  anode;
    logic [7:0]  catode;
    logic        frame_done;

    int passed;
    int total;

    hex_display_scan #(
        .N_DIGITS     (4),
        .DIV_COUNT    (3),
        .GUARD_CYCLES (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .data       (data),
        .dp         (dp),
        .blank      (blank),
        .lz_en      (lz_en),
        .data_valid (data_valid),
        .anode      (anode),
        .catode     (catode),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        data       = d;
        dp         = p;
        blank      = b;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
    endtask

    // Advance until frame_done is seen, bounded to a few frames.
    task automatic sync_frame(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (frame_done !== 1'b1 && n < 40);
        chk({tag, "_sync"}, 32'(frame_done), 32'd1);
    endtask

    // Starts on the frame_done cycle, checks all 12 cycles, ends on the next one.
    task automatic check_frame(input string tag, input logic [7:0] c3, input logic [7:0] c2,
                               input logic [7:0] c1, input logic [7:0] c0);
        logic [7:0] cat [4];
        int slot;
        int ph;
        cat[0] = c0;
        cat[1] = c1;
        cat[2] = c2;
        cat[3] = c3;
        for (int k = 0; k < 12; k++) begin
            slot = k / 3;
            ph   = k % 3;
            chk($sformatf("%s_k%0d_fd", tag, k), 32'(frame_done), (k == 0) ? 32'd1 : 32'd0);
            chk($sformatf("%s_k%0d_an", tag, k), 32'(anode), (ph == 0) ? 32'd0 : 32'(4'b0001 << slot));
            chk($sformatf("%s_k%0d_cat", tag, k), 32'(catode), (ph == 0) ? 32'd0 : 32'(cat[slot]));
            step();
        end
    endtask

    initial begin
        passed     = 0;
        total      = 0;
        reset      = 1'b1;
        enable     = 1'b1;
        data       = 16'h0000;
        dp         = 4'b0000;
        blank      = 4'b0000;
        lz_en      = 1'b0;
        data_valid = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_an", 32'(anode), 32'd0);
            chk("rst_cat", 32'(catode), 32'd0);
            chk("rst_fd", 32'(frame_done), 32'd0);
        end
        reset = 1'b0;
        step();
        chk("first_drive_an", 32'(anode), 32'h1);
        chk("first_drive_cat", 32'(catode), 32'h3F);
        chk("first_drive_fd", 32'(frame_done), 32'd0);

        load(16'h12AF, 4'b0000, 4'b0000);
        sync_frame("h12af");
        check_frame("h12af_a", 8'h06, 8'h5B, 8'h77, 8'h71);
        check_frame("h12af_b", 8'h06, 8'h5B, 8'h77, 8'h71);

        for (int i = 0; i < 7; i++) step();
        chk("en_d2_an", 32'(anode), 32'h4);
        chk("en_d2_cat", 32'(catode), 32'h5B);
        enable = 1'b0;
        step();
        chk("en_off_an", 32'(anode), 32'd0);
        chk("en_off_cat", 32'(catode), 32'd0);
        step();
        chk("en_off2_an", 32'(anode), 32'd0);
        chk("en_off2_fd", 32'(frame_done), 32'd0);
        enable = 1'b1;
        step();
        chk("en_guard_an", 32'(anode), 32'd0);
        chk("en_guard_cat", 32'(catode), 32'd0);
        chk("en_guard_fd", 32'(frame_done), 32'd0);
        step();
        chk("en_restart_an", 32'(anode), 32'h1);
        chk("en_restart_cat", 32'(catode), 32'h71);
        sync_frame("en_resume");
        check_frame("en_resume", 8'h06, 8'h5B, 8'h77, 8'h71);

        lz_en = 1'b1;
        load(16'h0030, 4'b0000, 4'b0000);
        sync_frame("lz0030");
        check_frame("lz0030", 8'h00, 8'h00, 8'h4F, 8'h3F);
        load(16'h0000, 4'b0000, 4'b0000);
        sync_frame("lz0000");
        check_frame("lz0000", 8'h00, 8'h00, 8'h00, 8'h3F);
        load(16'h1005, 4'b0000, 4'b0000);
        sync_frame("lz1005");
        check_frame("lz1005", 8'h06, 8'h3F, 8'h3F, 8'h6D);

        load(16'hBEEF, 4'b0000, 4'b0000);
        chk("tear_c1_an", 32'(anode), 32'h1);
        chk("tear_c1_cat", 32'(catode), 32'h6D);
        step();
        chk("tear_c2_cat", 32'(catode), 32'h6D);
        load(16'hC0DE, 4'b0000, 4'b0000);
        chk("tear_c3_an", 32'(anode), 32'd0);
        step();
        chk("tear_c4_an", 32'(anode), 32'h2);
        chk("tear_c4_cat", 32'(catode), 32'h3F);
        sync_frame("c0de");
        check_frame("c0de", 8'h39, 8'h3F, 8'h5E, 8'h79);

        load(16'h4567, 4'b0000, 4'b0000);
        for (int i = 0; i < 10; i++) step();
        load(16'h89AB, 4'b0000, 4'b0000);
        check_frame("wrap_old", 8'h66, 8'h6D, 8'h7D, 8'h07);
        check_frame("wrap_new", 8'h7F, 8'h6F, 8'h77, 8'h7C);

        lz_en = 1'b0;
        load(16'h1234, 4'b0101, 4'b0001);
        sync_frame("dpblank");
        check_frame("dpblank", 8'h06, 8'hDB, 8'h4F, 8'h00);
        lz_en = 1'b1;
        load(16'h0005, 4'b1000, 4'b0000);
        sync_frame("lzdp");
        check_frame("lzdp", 8'h80, 8'h00, 8'h00, 8'h6D);

        lz_en      = 1'b0;
        data       = 16'hFFFF;
        dp         = 4'b0000;
        blank      = 4'b0000;
        data_valid = 1'b1;
        reset      = 1'b1;
        step();
        reset      = 1'b0;
        data_valid = 1'b0;
        chk("midrst_an", 32'(anode), 32'd0);
        chk("midrst_cat", 32'(catode), 32'd0);
        chk("midrst_fd", 32'(frame_done), 32'd0);
        sync_frame("midrst");
        check_frame("midrst", 8'h3F, 8'h3F, 8'h3F, 8'h3F);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
